// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//
// In-order issue sequencer for the decode stage. Instructions arrive over a
// valid/ready port and are buffered in a small circular FIFO. The head entry is
// decoded by exact 32-bit match:
//   32'h0000257B -> class A, dispatched on a_* (single-cycle unit)
//   32'h0000277B -> class B, dispatched on b_* (multi-cycle, ends with b_done)
//   anything else -> illegal, held on trap_* until trap_ack flushes the queue
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_inst carries the instruction
//   a_valid/a_ready      unit A dispatch, a_inst carries the instruction
//   b_valid/b_ready      unit B dispatch, b_inst carries the instruction
//   b_done               unit B finished the outstanding instruction
//   trap_valid/trap_inst illegal encoding at head; trap_ack releases it
//   busy                 sequencer not idle or FIFO holds entries
//   perf_issued          saturating count of A/B dispatches
//   perf_illegal         saturating count of acknowledged traps
//
// Build option
//   DECODE_ISSUE_PERF_EN : when defined, the two performance counters are
//   implemented; otherwise perf_issued and perf_illegal are tied to zero.
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [31:0]      a_inst,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [31:0]      b_inst,
    input  logic             b_done,
    output logic             trap_valid,
    output logic [31:0]      trap_inst,
    input  logic             trap_ack,
    output logic             busy,
    output logic [CNT_W-1:0] perf_issued,
    output logic [CNT_W-1:0] perf_illegal
);

    localparam int              PTR_W    = $clog2(QDEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(QDEPTH);
    localparam logic [31:0]     INST_A   = 32'h0000_257B;
    localparam logic [31:0]     INST_B   = 32'h0000_277B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT_B,
        S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [31:0]      r_mem [QDEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_next;

    logic [31:0]      w_head;
    logic             w_is_a;
    logic             w_is_b;
    logic             w_push;
    logic             w_pop;
    logic             w_a_fire;
    logic             w_b_fire;
    logic             w_flush;

    // ---------------------------------------------------------------- FIFO --
    assign w_head   = r_mem[r_rd_ptr];
    assign w_is_a   = (w_head == INST_A);
    assign w_is_b   = (w_head == INST_B);

    // in_ready looks only at registered count: a pop in the same cycle does
    // not make room for a push into a full queue.
    assign in_ready = (r_count != FULL_CNT) && (r_state != S_TRAP);
    assign w_push   = in_valid && in_ready;
    assign w_a_fire = a_valid && a_ready;
    assign w_b_fire = b_valid && b_ready;
    assign w_pop    = w_a_fire || w_b_fire;
    assign w_flush  = (r_state == S_TRAP) && trap_ack;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the storage array is not reset; an entry is only read while the
    // count says it is valid, so clearing pointers and count is sufficient.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_inst;
    end

    // ----------------------------------------------------------------- FSM --
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Decisions use the post-update count so IDLE always means an empty queue.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_count_next != '0) w_state_next = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (w_b_fire) begin
                    w_state_next = S_WAIT_B;
                end else if (w_a_fire) begin
                    w_state_next = (w_count_next != '0) ? S_DISPATCH : S_IDLE;
                end else if (!w_is_a && !w_is_b) begin
                    w_state_next = S_TRAP;
                end
            end
            S_WAIT_B: begin
                if (b_done) w_state_next = (w_count_next != '0) ? S_DISPATCH : S_IDLE;
            end
            S_TRAP: begin
                if (trap_ack) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs depend on registered state and FIFO head only.
    always_comb begin
        a_valid    = 1'b0;
        a_inst     = '0;
        b_valid    = 1'b0;
        b_inst     = '0;
        trap_valid = 1'b0;
        trap_inst  = '0;
        case (r_state)
            S_DISPATCH: begin
                if (w_is_a) begin
                    a_valid = 1'b1;
                    a_inst  = w_head;
                end else if (w_is_b) begin
                    b_valid = 1'b1;
                    b_inst  = w_head;
                end
            end
            S_TRAP: begin
                trap_valid = 1'b1;
                trap_inst  = w_head;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != S_IDLE) || (r_count != '0);

    // -------------------------------------------------------- perf counters --
`ifdef DECODE_ISSUE_PERF_EN
    logic [CNT_W-1:0] r_perf_issued;
    logic [CNT_W-1:0] r_perf_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_issued  <= '0;
            r_perf_illegal <= '0;
        end else begin
            if (w_pop && (r_perf_issued != '1))
                r_perf_issued <= r_perf_issued + 1'b1;
            if (w_flush && (r_perf_illegal != '1))
                r_perf_illegal <= r_perf_illegal + 1'b1;
        end
    end

    assign perf_issued  = r_perf_issued;
    assign perf_illegal = r_perf_illegal;
`else
    assign perf_issued  = '0;
    assign perf_illegal = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_ctrl
//
// Self-checking bench for decode_issue_ctrl (QDEPTH=2, CNT_W=4). A queue-based
// reference model tracks the instruction queue plus "waiting on B" and
// "trapped" flags and predicts every output each cycle. On top of that a
// table of directed vectors and a few hand-written sequences compare against
// fixed expected values. Honours DECODE_ISSUE_PERF_EN for counter checks.
// -----------------------------------------------------------------------------
module tb_decode_issue_ctrl;

    localparam int          QDEPTH = 2;
    localparam int          CNT_W  = 4;
    localparam int          SAT    = (1 << CNT_W) - 1;
    localparam logic [31:0] IA     = 32'h0000_257B;
    localparam logic [31:0] IB     = 32'h0000_277B;
    localparam logic [31:0] ILL    = 32'h1234_5678;
`ifdef DECODE_ISSUE_PERF_EN
    localparam bit          PERF_EN = 1'b1;
`else
    localparam bit          PERF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic             a_valid;
    logic             a_ready;
    logic [31:0]      a_inst;
    logic             b_valid;
    logic             b_ready;
    logic [31:0]      b_inst;
    logic             b_done;
    logic             trap_valid;
    logic [31:0]      trap_inst;
    logic             trap_ack;
    logic             busy;
    logic [CNT_W-1:0] perf_issued;
    logic [CNT_W-1:0] perf_illegal;

    decode_issue_ctrl #(.QDEPTH(QDEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_inst      (in_inst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_inst       (a_inst),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_inst       (b_inst),
        .b_done       (b_done),
        .trap_valid   (trap_valid),
        .trap_inst    (trap_inst),
        .trap_ack     (trap_ack),
        .busy         (busy),
        .perf_issued  (perf_issued),
        .perf_illegal (perf_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ reference model --
    logic [31:0] mq[$];
    bit          m_waitb;
    bit          m_trap;
    int          m_issued;
    int          m_illegal;

    logic [31:0] dut_log[$];  // instructions seen firing on a_*/b_*

    task automatic model_reset();
        mq.delete();
        m_waitb   = 1'b0;
        m_trap    = 1'b0;
        m_issued  = 0;
        m_illegal = 0;
    endtask

    task automatic check_model();
        bit          disp;
        logic [31:0] h;
        bit          ea;
        bit          eb;
        disp = (mq.size() > 0) && !m_waitb && !m_trap;
        h    = (mq.size() > 0) ? mq[0] : 32'h0;
        ea   = disp && (h == IA);
        eb   = disp && (h == IB);
        check("mdl in_ready",   32'(in_ready),   32'((mq.size() < QDEPTH) && !m_trap));
        check("mdl a_valid",    32'(a_valid),    32'(ea));
        check("mdl b_valid",    32'(b_valid),    32'(eb));
        check("mdl trap_valid", 32'(trap_valid), 32'(m_trap));
        check("mdl a_inst",     a_inst,          ea ? h : 32'h0);
        check("mdl b_inst",     b_inst,          eb ? h : 32'h0);
        check("mdl trap_inst",  trap_inst,       m_trap ? h : 32'h0);
        check("mdl busy",       32'(busy),       32'((mq.size() > 0) || m_waitb || m_trap));
        check("mdl perf_issued",  32'(perf_issued),  PERF_EN ? 32'(m_issued)  : 32'h0);
        check("mdl perf_illegal", 32'(perf_illegal), PERF_EN ? 32'(m_illegal) : 32'h0);
    endtask

    task automatic model_update(input bit rst, input bit iv, input logic [31:0] ii,
                                input bit ar, input bit br, input bit bd, input bit ta);
        bit          disp;
        logic [31:0] h;
        bit          ea;
        bit          eb;
        bit          push;
        if (rst) begin
            model_reset();
            return;
        end
        disp = (mq.size() > 0) && !m_waitb && !m_trap;
        h    = (mq.size() > 0) ? mq[0] : 32'h0;
        ea   = disp && (h == IA);
        eb   = disp && (h == IB);
        push = iv && (mq.size() < QDEPTH) && !m_trap;
        if (m_trap && ta) begin
            mq.delete();
            m_trap = 1'b0;
            if (m_illegal < SAT) m_illegal++;
        end else begin
            if ((ea && ar) || (eb && br)) begin
                void'(mq.pop_front());
                if (m_issued < SAT) m_issued++;
            end
            if (push) mq.push_back(ii);
            if (disp && !ea && !eb) m_trap = 1'b1;
            if (eb && br)             m_waitb = 1'b1;
            else if (m_waitb && bd)   m_waitb = 1'b0;
        end
    endtask

    // One clock cycle, entered and left just after a falling edge: compare
    // against the model, drive inputs, advance the model, wait for next negedge.
    task automatic step(input bit rst, input bit iv, input logic [31:0] ii,
                        input bit ar, input bit br, input bit bd, input bit ta);
        check_model();
        if (!rst && a_valid && ar) dut_log.push_back(a_inst);
        if (!rst && b_valid && br) dut_log.push_back(b_inst);
        reset    = rst;
        in_valid = iv;
        in_inst  = ii;
        a_ready  = ar;
        b_ready  = br;
        b_done   = bd;
        trap_ack = ta;
        model_update(rst, iv, ii, ar, br, bd, ta);
        @(negedge clk);
    endtask

    // ------------------------------------------------------ directed table --
    typedef struct {
        bit          iv;
        logic [31:0] ii;
        bit          ar, br, bd, ta;
        bit          e_av, e_bv, e_tv, e_ir, e_busy;
        logic [31:0] e_inst;   // a_inst | b_inst | trap_inst
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit iv, logic [31:0] ii, bit ar, bit br, bit bd, bit ta,
                                bit e_av, bit e_bv, bit e_tv, bit e_ir, bit e_busy,
                                logic [31:0] e_inst);
        vec_t v;
        v.iv = iv; v.ii = ii; v.ar = ar; v.br = br; v.bd = bd; v.ta = ta;
        v.e_av = e_av; v.e_bv = e_bv; v.e_tv = e_tv; v.e_ir = e_ir;
        v.e_busy = e_busy; v.e_inst = e_inst;
        return v;
    endfunction

    initial begin
        bit          pend;
        bit          prev_iv;
        bit          prev_ir;
        logic [31:0] prev_ii;
        logic [31:0] ri;
        bit          riv;
        int          sel;

        // Class A stream: four back-to-back accepts and fires.
        vecs.push_back(mk(1, IA, 1, 0, 0, 0,  0, 0, 0, 1, 0, 32'h0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, IA, 1, 0, 0, 0,  1, 0, 0, 1, 1, IA));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0,  1, 0, 0, 1, 1, IA));
        // B then A: A waits for b_done five cycles after the B fire.
        vecs.push_back(mk(1, IB, 1, 1, 0, 0,  0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, IA, 0, 1, 0, 0,  0, 1, 0, 1, 1, IB));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 1,  0, 0, 0, 1, 1, 32'h0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h0, 0, 0, 1, 0,  0, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 32'h0, 1, 0, 0, 0,  1, 0, 0, 1, 1, IA));
        // Illegal then A: trap held ten cycles, then acknowledged and flushed.
        vecs.push_back(mk(1, ILL, 0, 0, 0, 0,  0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(1, IA, 0, 0, 0, 0,  0, 0, 0, 1, 1, 32'h0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 32'h0, 1, 1, 1, 0,  0, 0, 1, 0, 1, ILL));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 1,  0, 0, 1, 0, 1, ILL));
        vecs.push_back(mk(0, 32'h0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0, 1, 1, 0, 0,  0, 0, 0, 1, 0, 32'h0));

        reset    = 1'b1;
        in_valid = 1'b0;
        in_inst  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        b_done   = 1'b0;
        trap_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // Reset state.
        check("rst in_ready",     32'(in_ready),     32'h1);
        check("rst busy",         32'(busy),         32'h0);
        check("rst a_valid",      32'(a_valid),      32'h0);
        check("rst b_valid",      32'(b_valid),      32'h0);
        check("rst trap_valid",   32'(trap_valid),   32'h0);
        check("rst insts",        a_inst | b_inst | trap_inst, 32'h0);
        check("rst perf_issued",  32'(perf_issued),  32'h0);
        check("rst perf_illegal", 32'(perf_illegal), 32'h0);

        foreach (vecs[i]) begin
            check($sformatf("vec%0d a_valid", i),    32'(a_valid),    32'(vecs[i].e_av));
            check($sformatf("vec%0d b_valid", i),    32'(b_valid),    32'(vecs[i].e_bv));
            check($sformatf("vec%0d trap_valid", i), 32'(trap_valid), 32'(vecs[i].e_tv));
            check($sformatf("vec%0d in_ready", i),   32'(in_ready),   32'(vecs[i].e_ir));
            check($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].e_busy));
            check($sformatf("vec%0d inst", i),       a_inst | b_inst | trap_inst, vecs[i].e_inst);
            step(1'b0, vecs[i].iv, vecs[i].ii, vecs[i].ar, vecs[i].br, vecs[i].bd, vecs[i].ta);
        end
        check("vec perf_issued",  32'(perf_issued),  PERF_EN ? 32'd6 : 32'd0);
        check("vec perf_illegal", 32'(perf_illegal), PERF_EN ? 32'd1 : 32'd0);

        // Fill to full with units stalled, hold a third, then drain in order.
        step(1'b1, 0, 32'h0, 0, 0, 0, 0);
        dut_log.delete();
        step(1'b0, 1, IA, 0, 0, 0, 0);
        step(1'b0, 1, IB, 0, 0, 0, 0);
        check("full in_ready", 32'(in_ready), 32'h0);
        step(1'b0, 1, IA, 0, 0, 0, 0);
        step(1'b0, 1, IA, 0, 0, 0, 0);
        check("full in_ready held", 32'(in_ready), 32'h0);
        pend = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bit acc;
            acc = pend && in_ready;
            step(1'b0, pend, IA, 1, 1, 1, 0);
            if (acc) pend = 1'b0;
        end
        check("drain count", 32'(dut_log.size()), 32'd3);
        check("drain 0", (dut_log.size() > 0) ? dut_log[0] : 32'h0, IA);
        check("drain 1", (dut_log.size() > 1) ? dut_log[1] : 32'h0, IB);
        check("drain 2", (dut_log.size() > 2) ? dut_log[2] : 32'h0, IA);

        // Reset while waiting on B with one entry queued; late b_done ignored.
        step(1'b1, 0, 32'h0, 0, 0, 0, 0);
        step(1'b0, 1, IB, 0, 0, 0, 0);
        step(1'b0, 1, IA, 0, 1, 0, 0);
        check("waitb busy",    32'(busy),    32'h1);
        check("waitb a_valid", 32'(a_valid), 32'h0);
        step(1'b1, 0, 32'h0, 1, 1, 0, 0);
        check("rstmid valids", 32'({a_valid, b_valid, trap_valid}), 32'h0);
        check("rstmid busy",   32'(busy), 32'h0);
        step(1'b0, 0, 32'h0, 1, 1, 1, 0);
        check("late bdone valids", 32'({a_valid, b_valid, trap_valid}), 32'h0);
        check("late bdone busy",   32'(busy), 32'h0);

        // Seventeen class A fires saturate a 4-bit issue counter.
        step(1'b1, 0, 32'h0, 0, 0, 0, 0);
        dut_log.delete();
        for (int i = 0; i < 17; i++) step(1'b0, 1, IA, 1, 0, 0, 0);
        step(1'b0, 0, 32'h0, 1, 0, 0, 0);
        check("sat fires", 32'(dut_log.size()), 32'd17);
        check("sat perf_issued", 32'(perf_issued), PERF_EN ? 32'hF : 32'h0);

        // Randomized traffic against the model.
        step(1'b1, 0, 32'h0, 0, 0, 0, 0);
        prev_iv = 1'b0;
        prev_ir = 1'b1;
        prev_ii = '0;
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            rst = ($urandom_range(0, 299) == 0);
            if (prev_iv && !prev_ir) begin
                riv = 1'b1;
                ri  = prev_ii;
            end else begin
                riv = ($urandom_range(0, 2) != 0);
                sel = $urandom_range(0, 9);
                if (sel <= 3)      ri = IA;
                else if (sel <= 6) ri = IB;
                else if (sel == 7) ri = $urandom;
                else if (sel == 8) ri = 32'h0000_257A;
                else               ri = IB ^ (32'h1 << $urandom_range(0, 31));
            end
            prev_ir = in_ready;
            prev_iv = riv && !rst;
            prev_ii = ri;
            step(rst, riv, ri, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end
        check_model();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
